// File: rtl/tp_sequencer.sv
// rtl/tp_sequencer.sv - timepulse sequencer: divides clk into NUM_TP one-hot timepulses per memory cycle
// Outputs are registered one clock behind the internal state, so every output describes the same cycle.
module tp_sequencer #(
  parameter int NUM_TP = 12,
  parameter int DIV    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step_req,
  input  logic              gojam,
  output logic [NUM_TP-1:0] tp,
  output logic [3:0]        tp_idx,
  output logic              tp_first,
  output logic              mct_end,
  output logic              step_ack,
  output logic              busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [3:0]    IDX_MAX = 4'(NUM_TP - 1);

  typedef enum logic [1:0] {HALT, RUN, DRAIN, STEP} state_t;

  state_t            state;
  logic [CW-1:0]     div_cnt;
  logic [3:0]        idx;
  logic              step_armed;
  logic              jam_q;
  logic              tp_end;
  logic              mct_last;
  logic              active;
  logic [NUM_TP-1:0] one_hot;

  assign tp_end   = (div_cnt == CNT_MAX);
  assign mct_last = tp_end && (idx == IDX_MAX);
  assign active   = (state != HALT);

  always_comb begin
    one_hot      = '0;
    one_hot[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HALT;
      div_cnt    <= '0;
      idx        <= '0;
      step_armed <= 1'b1;
      jam_q      <= 1'b0;
      tp         <= '0;
      tp_idx     <= '0;
      tp_first   <= 1'b0;
      mct_end    <= 1'b0;
      step_ack   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tp       <= active ? one_hot : '0;
      tp_idx   <= active ? idx : 4'd0;
      // A restart marks the following cycle as a timepulse start even when it lands in HALT.
      tp_first <= (active && (div_cnt == '0)) || jam_q;
      mct_end  <= active && mct_last && !gojam;
      step_ack <= (state == STEP) && mct_last && !gojam;
      busy     <= active;
      jam_q    <= gojam;

      if (gojam) begin
        idx     <= '0;
        div_cnt <= '0;
        state   <= run ? RUN : HALT;
      end else begin
        if (active) begin
          if (tp_end) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_MAX) ? 4'd0 : idx + 4'd1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        case (state)
          HALT: begin
            if (run) state <= RUN;
            else if (step_req && step_armed) state <= STEP;
            // Any request seen while halted is consumed; only a low sample re-arms.
            step_armed <= !step_req;
          end
          RUN: begin
            if (!run) state <= mct_last ? HALT : DRAIN;
          end
          DRAIN: begin
            if (run) state <= RUN;
            else if (mct_last) state <= HALT;
          end
          STEP: begin
            if (mct_last) state <= run ? RUN : HALT;
          end
          default: state <= HALT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tp_sequencer.sv
// tb/tb_tp_sequencer.sv - directed scoreboard bench for tp_sequencer (NUM_TP=12, DIV=2)
module tb_tp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        step_req;
  logic        gojam;
  logic [11:0] tp;
  logic [3:0]  tp_idx;
  logic        tp_first;
  logic        mct_end;
  logic        step_ack;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  string tag;

  typedef logic [19:0] vec_t;
  vec_t exp_q[$];

  tp_sequencer #(.NUM_TP(12), .DIV(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .step_req (step_req),
    .gojam    (gojam),
    .tp       (tp),
    .tp_idx   (tp_idx),
    .tp_first (tp_first),
    .mct_end  (mct_end),
    .step_ack (step_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t observed();
    return {tp, tp_idx, tp_first, mct_end, step_ack, busy};
  endfunction

  task automatic push_exp(input int idx, input bit on, input bit first, input bit mend, input bit sack);
    logic [11:0] one;
    one = 12'd1;
    exp_q.push_back({on ? (one << idx) : 12'd0, on ? 4'(idx) : 4'd0, first, mend, sack, on});
  endtask

  task automatic push_halt(input int n);
    for (int i = 0; i < n; i++) push_exp(0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Two clocks per timepulse; mct_end (and step_ack for a step MCT) on the last clock of T12.
  task automatic push_span(input int start_idx, input int start_cnt, input int n, input bit step_mct);
    int idx;
    int cnt;
    idx = start_idx;
    cnt = start_cnt;
    for (int i = 0; i < n; i++) begin
      push_exp(idx, 1'b1, cnt == 0, (idx == 11) && (cnt == 1), step_mct && (idx == 11) && (cnt == 1));
      cnt++;
      if (cnt == 2) begin
        cnt = 0;
        idx = (idx + 1) % 12;
      end
    end
  endtask

  task automatic check_now(input vec_t exp);
    vec_t obs;
    obs = observed();
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    vec_t exp;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check_now(exp);
    end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; step_req = 1'b0; gojam = 1'b0;
    #3;
    tag = "reset_state";
    check_now(20'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    tag = "free_run";
    run = 1'b1;
    push_halt(1);
    push_span(0, 0, 33, 1'b0);
    drain();
    tag = "drain";
    run = 1'b0;
    push_span(4, 1, 15, 1'b0);
    push_halt(2);
    drain();

    tag = "run_to_t07";
    run = 1'b1;
    push_halt(1);
    push_span(0, 0, 13, 1'b0);
    drain();
    rst = 1'b0;
    #1;
    tag = "async_reset";
    check_now(20'd0);
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tag = "after_reset";
    push_halt(2);
    drain();

    tag = "step_held";
    step_req = 1'b1;
    push_halt(1);
    push_span(0, 0, 24, 1'b1);
    push_halt(35);
    drain();
    tag = "step_rearm";
    step_req = 1'b0;
    push_halt(1);
    drain();
    step_req = 1'b1;
    push_halt(1);
    push_span(0, 0, 24, 1'b1);
    push_halt(2);
    drain();
    step_req = 1'b0;
    push_halt(1);
    drain();

    tag = "gojam_setup";
    run = 1'b1;
    push_halt(1);
    push_span(0, 0, 13, 1'b0);
    drain();
    tag = "gojam_t07";
    gojam = 1'b1;
    push_span(6, 1, 1, 1'b0);
    drain();
    gojam = 1'b0;
    push_span(0, 0, 23, 1'b0);
    drain();
    tag = "gojam_last_held";
    gojam = 1'b1;
    push_exp(11, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp(0, 1'b1, 1'b1, 1'b0, 1'b0);
    push_exp(0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    gojam = 1'b0;
    push_span(0, 0, 24, 1'b0);
    drain();
    tag = "gojam_drain";
    run = 1'b0;
    push_span(0, 0, 24, 1'b0);
    push_halt(2);
    drain();

    tag = "run_and_step";
    run = 1'b1;
    step_req = 1'b1;
    push_halt(1);
    push_span(0, 0, 24, 1'b0);
    drain();
    run = 1'b0;
    push_span(0, 0, 24, 1'b0);
    push_halt(4);
    drain();
    step_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
